// File: rtl/waypoint_pkg.sv
// Shared types for the waypoint collector.
//   wp_state_t : controller state encoding
//   BTN_*      : bit positions of the buttons in the edge-detector vector
package waypoint_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GET_X  = 3'd1,
        GET_Y  = 3'd2,
        WRITE  = 3'd3,
        OPTION = 3'd4,
        DONE   = 3'd5
    } wp_state_t;

    localparam int unsigned BTN_WR   = 0;
    localparam int unsigned BTN_NEW  = 1;
    localparam int unsigned BTN_FIN  = 2;
    localparam int unsigned BTN_UNDO = 3;
    localparam int unsigned BTN_N    = 4;

endpackage

// File: rtl/waypoint_collector_if.sv
// Memory write port of the waypoint collector.
//   mem_addr  : write address
//   mem_wdata : packed {x, y} write data, x in the high half
//   mem_wren  : one-cycle write strobe
// master = collector side, slave = memory side.
interface waypoint_collector_if #(
    parameter int unsigned COORD_W = 8,
    parameter int unsigned DEPTH   = 256
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0]    mem_addr;
    logic [2*COORD_W-1:0] mem_wdata;
    logic                 mem_wren;

    modport master (output mem_addr, output mem_wdata, output mem_wren);
    modport slave  (input  mem_addr, input  mem_wdata, input  mem_wren);
endinterface

// File: rtl/waypoint_collector_rise_detect.sv
// Rising-edge detector for a vector of synchronous level inputs.
//   clk, reset : clock, asynchronous active-high reset (clears history to 0)
//   din        : level inputs
//   rise       : high for the first cycle each input is seen high
module rise_detect #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] rise
);
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) prev_q <= '0;
        else       prev_q <= din;
    end

    assign rise = din & ~prev_q;
endmodule

// File: rtl/waypoint_collector.sv
// Waypoint collector: enter X then Y with write_en, commit the pair to memory,
// then choose finish / enter_new (/ undo) until done or memory is full.
//   clk, reset                         : clock, asynchronous active-high reset
//   x_in, y_in                         : coordinate switches
//   write_en, enter_new, finish, undo  : level buttons, synchronous to clk
//   mem                                : memory write port (master)
//   disp_x, disp_y                     : latched components for the display
//   count                              : committed waypoints
//   full, done, err                    : status; err is a one-cycle pulse
// Build option: define WAYPOINT_UNDO_EN to enable the undo button.
module waypoint_collector
    import waypoint_pkg::*;
#(
    parameter int unsigned COORD_W = 8,
    parameter int unsigned DEPTH   = 256
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [COORD_W-1:0]           x_in,
    input  logic [COORD_W-1:0]           y_in,
    input  logic                         write_en,
    input  logic                         enter_new,
    input  logic                         finish,
    input  logic                         undo,
    waypoint_collector_if.master         mem,
    output logic [COORD_W-1:0]           disp_x,
    output logic [COORD_W-1:0]           disp_y,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         full,
    output logic                         done,
    output logic                         err
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    wp_state_t          state_q, state_d;
    logic [ADDR_W:0]    count_q, count_d;
    logic [COORD_W-1:0] disp_x_q, disp_x_d, disp_y_q, disp_y_d;
    logic               err_q, err_d;
    logic [BTN_N-1:0]   btn, ev;

    assign btn[BTN_WR]  = write_en;
    assign btn[BTN_NEW] = enter_new;
    assign btn[BTN_FIN] = finish;
`ifdef WAYPOINT_UNDO_EN
    assign btn[BTN_UNDO] = undo;
`else
    assign btn[BTN_UNDO] = 1'b0;
    // Lint sink only: undo is not connected to any state.
    logic unused_undo;
    assign unused_undo = undo ^ ev[BTN_UNDO];
`endif

    rise_detect #(
        .WIDTH (BTN_N)
    ) u_rise_detect (
        .clk   (clk),
        .reset (reset),
        .din   (btn),
        .rise  (ev)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        disp_x_d = disp_x_q;
        disp_y_d = disp_y_q;
        err_d    = 1'b0;
        case (state_q)
            IDLE: state_d = GET_X;
            GET_X: begin
                if (ev[BTN_WR]) begin
                    disp_x_d = x_in;
                    state_d  = GET_Y;
                end
            end
            GET_Y: begin
                if (ev[BTN_WR]) begin
                    disp_y_d = y_in;
                    state_d  = WRITE;
                end
            end
            WRITE: begin
                count_d = count_q + 1'b1;
                state_d = OPTION;
            end
            OPTION: begin
                if (ev[BTN_FIN]) begin
                    disp_x_d = '0;
                    disp_y_d = '0;
                    state_d  = DONE;
                end else if (ev[BTN_NEW]) begin
                    if (full) err_d   = 1'b1;
                    else      state_d = GET_X;
                end
`ifdef WAYPOINT_UNDO_EN
                else if (ev[BTN_UNDO]) begin
                    if (count_q != '0) count_d = count_q - 1'b1;
                    else               err_d   = 1'b1;
                end
`endif
            end
            DONE: state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            disp_x_q <= '0;
            disp_y_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            disp_x_q <= disp_x_d;
            disp_y_q <= disp_y_d;
            err_q    <= err_d;
        end
    end

    // Address tracks count in every state; count < DEPTH whenever WRITE is reachable.
    assign mem.mem_addr  = count_q[ADDR_W-1:0];
    assign mem.mem_wdata = {disp_x_q, disp_y_q};
    assign mem.mem_wren  = (state_q == WRITE);

    assign disp_x = disp_x_q;
    assign disp_y = disp_y_q;
    assign count  = count_q;
    assign full   = (count_q == FULL_COUNT);
    assign done   = (state_q == DONE);
    assign err    = err_q;
endmodule

// File: tb/tb_waypoint_collector.sv
module tb_waypoint_collector;
    import waypoint_pkg::*;

    localparam int unsigned COORD_W = 8;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned ADDR_W  = 2;
    localparam int unsigned REC_W   = ADDR_W + 2 * COORD_W;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [COORD_W-1:0] x_in = '0, y_in = '0;
    logic               write_en = 1'b0, enter_new = 1'b0, finish = 1'b0, undo = 1'b0;
    logic [COORD_W-1:0] disp_x, disp_y;
    logic [ADDR_W:0]    count;
    logic               full, done, err;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_count = 0;
    int err_seen = 0;
    logic [REC_W-1:0] exp_q[$];
    logic [REC_W-1:0] obs_q[$];

    waypoint_collector_if #(.COORD_W(COORD_W), .DEPTH(DEPTH)) mem_if ();

    waypoint_collector #(.COORD_W(COORD_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .x_in      (x_in),
        .y_in      (y_in),
        .write_en  (write_en),
        .enter_new (enter_new),
        .finish    (finish),
        .undo      (undo),
        .mem       (mem_if),
        .disp_x    (disp_x),
        .disp_y    (disp_y),
        .count     (count),
        .full      (full),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Record every write strobe and err pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_if.mem_wren) obs_q.push_back({mem_if.mem_addr, mem_if.mem_wdata});
        if (err) err_seen++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic wr, input logic nw, input logic fin, input logic un);
        write_en = wr; enter_new = nw; finish = fin; undo = un;
        tick();
        write_en = 1'b0; enter_new = 1'b0; finish = 1'b0; undo = 1'b0;
        tick();
    endtask

    task automatic enter_point(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
        logic [ADDR_W-1:0] a;
        a = exp_count[ADDR_W-1:0];
        x_in = x;
        press(1'b1, 1'b0, 1'b0, 1'b0);
        y_in = y;
        exp_q.push_back({a, x, y});
        press(1'b1, 1'b0, 1'b0, 1'b0);
        exp_count++;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_checks++;
        if (dut.state_q !== IDLE) begin
            n_fail++; $display("FAIL reset_state got %0d want %0d", dut.state_q, IDLE);
        end
        n_checks++;
        if ({count, mem_if.mem_addr, mem_if.mem_wdata, mem_if.mem_wren} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got cnt=%0d addr=%0d wdata=%h wren=%b want zeros",
                     count, mem_if.mem_addr, mem_if.mem_wdata, mem_if.mem_wren);
        end
        n_checks++;
        if ({disp_x, disp_y, full, done, err} !== '0) begin
            n_fail++;
            $display("FAIL reset_status got dx=%h dy=%h full=%b done=%b err=%b want zeros",
                     disp_x, disp_y, full, done, err);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (dut.state_q !== GET_X) begin
            n_fail++; $display("FAIL leave_idle got %0d want %0d", dut.state_q, GET_X);
        end
    endtask

    task automatic test_basic_write();
        logic [REC_W-1:0] e, o;
        enter_point(8'h12, 8'h34);
        n_checks++;
        if (count !== 3'd1) begin
            n_fail++; $display("FAIL basic_count got %0d want 1", count);
        end
        n_checks++;
        if (dut.state_q !== OPTION || disp_x !== 8'h12 || disp_y !== 8'h34) begin
            n_fail++;
            $display("FAIL basic_state got st=%0d dx=%h dy=%h want %0d 12 34",
                     dut.state_q, disp_x, disp_y, OPTION);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++; $display("FAIL basic_write got none want %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++; $display("FAIL basic_write got %h want %h", o, e);
                end
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++; $display("FAIL basic_extra got %0d writes want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_held_write();
        logic [REC_W-1:0] e, o;
        press(1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (dut.state_q !== GET_X) begin
            n_fail++; $display("FAIL held_new got %0d want %0d", dut.state_q, GET_X);
        end
        x_in = 8'h56;
        write_en = 1'b1;
        repeat (10) tick();
        n_checks++;
        if (dut.state_q !== GET_Y || obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL held_one_event got st=%0d writes=%0d want %0d 0",
                     dut.state_q, obs_q.size(), GET_Y);
        end
        write_en = 1'b0;
        tick();
        y_in = 8'h78;
        exp_q.push_back({2'd1, 8'h56, 8'h78});
        press(1'b1, 1'b0, 1'b0, 1'b0);
        exp_count++;
        n_checks++;
        if (count !== 3'd2) begin
            n_fail++; $display("FAIL held_count got %0d want 2", count);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++; $display("FAIL held_write got none want %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++; $display("FAIL held_write got %h want %h", o, e);
                end
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++; $display("FAIL held_extra got %0d writes want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_full();
        logic [REC_W-1:0] e, o;
        int err0;
        press(1'b0, 1'b1, 1'b0, 1'b0);
        enter_point(8'h9A, 8'hBC);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        enter_point(8'hDE, 8'hF0);
        n_checks++;
        if (full !== 1'b1 || count !== 3'd4) begin
            n_fail++; $display("FAIL full_flag got full=%b cnt=%0d want 1 4", full, count);
        end
        n_checks++;
        if (mem_if.mem_addr !== 2'd0 || mem_if.mem_wren !== 1'b0) begin
            n_fail++;
            $display("FAIL full_addr got addr=%0d wren=%b want 0 0",
                     mem_if.mem_addr, mem_if.mem_wren);
        end
        err0 = err_seen;
        press(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) tick();
        n_checks++;
        if (err_seen - err0 != 1) begin
            n_fail++; $display("FAIL full_err got %0d pulses want 1", err_seen - err0);
        end
        n_checks++;
        if (dut.state_q !== OPTION || count !== 3'd4) begin
            n_fail++;
            $display("FAIL full_stay got st=%0d cnt=%0d want %0d 4", dut.state_q, count, OPTION);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++; $display("FAIL full_write got none want %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++; $display("FAIL full_write got %h want %h", o, e);
                end
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++; $display("FAIL full_extra got %0d writes want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_finish_priority();
        press(1'b0, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (dut.state_q !== DONE || done !== 1'b1 || count !== 3'd4) begin
            n_fail++;
            $display("FAIL finish_prio got st=%0d done=%b cnt=%0d want %0d 1 4",
                     dut.state_q, done, count, DONE);
        end
        n_checks++;
        if (disp_x !== 8'h00 || disp_y !== 8'h00) begin
            n_fail++; $display("FAIL finish_disp got %h %h want 00 00", disp_x, disp_y);
        end
        x_in = 8'h01;
        press(1'b1, 1'b0, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (dut.state_q !== DONE || count !== 3'd4 || obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL done_sticky got st=%0d cnt=%0d writes=%0d want %0d 4 0",
                     dut.state_q, count, obs_q.size(), DONE);
            obs_q.delete();
        end
    endtask

    task automatic test_undo();
        logic [REC_W-1:0] e, o;
        int err0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        exp_count = 0;
        enter_point(8'h11, 8'h22);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        enter_point(8'h33, 8'h44);
`ifdef WAYPOINT_UNDO_EN
        press(1'b0, 1'b0, 1'b0, 1'b1);
        exp_count--;
        n_checks++;
        if (count !== 3'd1 || dut.state_q !== OPTION) begin
            n_fail++;
            $display("FAIL undo_dec got cnt=%0d st=%0d want 1 %0d", count, dut.state_q, OPTION);
        end
        press(1'b0, 1'b1, 1'b0, 1'b0);
        enter_point(8'h55, 8'h66);
        press(1'b0, 1'b0, 1'b0, 1'b1);
        press(1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (count !== 3'd0) begin
            n_fail++; $display("FAIL undo_zero got %0d want 0", count);
        end
        err0 = err_seen;
        press(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        n_checks++;
        if (err_seen - err0 != 1 || count !== 3'd0) begin
            n_fail++;
            $display("FAIL undo_err got pulses=%0d cnt=%0d want 1 0", err_seen - err0, count);
        end
`else
        err0 = err_seen;
        press(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        n_checks++;
        if (count !== 3'd2 || err_seen != err0 || dut.state_q !== OPTION) begin
            n_fail++;
            $display("FAIL undo_ignored got cnt=%0d pulses=%0d st=%0d want 2 0 %0d",
                     count, err_seen - err0, dut.state_q, OPTION);
        end
`endif
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_fail++; $display("FAIL undo_write got none want %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_fail++; $display("FAIL undo_write got %h want %h", o, e);
                end
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++; $display("FAIL undo_extra got %0d writes want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_reset_in_write();
        press(1'b0, 1'b1, 1'b0, 1'b0);
        x_in = 8'hAA;
        press(1'b1, 1'b0, 1'b0, 1'b0);
        y_in = 8'hBB;
        write_en = 1'b1;
        tick();
        n_checks++;
        if (dut.state_q !== WRITE || mem_if.mem_wren !== 1'b1) begin
            n_fail++;
            $display("FAIL rstw_setup got st=%0d wren=%b want %0d 1",
                     dut.state_q, mem_if.mem_wren, WRITE);
        end
        reset = 1'b1;
        write_en = 1'b0;
        #1;
        n_checks++;
        if (mem_if.mem_wren !== 1'b0 || count !== 3'd0 || dut.state_q !== IDLE) begin
            n_fail++;
            $display("FAIL rstw_async got wren=%b cnt=%0d st=%0d want 0 0 %0d",
                     mem_if.mem_wren, count, dut.state_q, IDLE);
        end
        n_checks++;
        if (disp_x !== 8'h00 || disp_y !== 8'h00 || dut.u_rise_detect.prev_q !== 4'b0) begin
            n_fail++;
            $display("FAIL rstw_clear got dx=%h dy=%h hist=%b want 00 00 0000",
                     disp_x, disp_y, dut.u_rise_detect.prev_q);
        end
        tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if (dut.state_q !== GET_X || obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL rstw_after got st=%0d writes=%0d want %0d 0",
                     dut.state_q, obs_q.size(), GET_X);
            obs_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_held_write();
        test_full();
        test_finish_priority();
        test_undo();
        test_reset_in_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
